// File: rtl/subleq_datapath.sv
// Register/arithmetic datapath for the SUBLEQ machine: PC, A/B/C, VA/VB, RES, bus muxing and VB-VA.
// Optional halt detection on negative jump targets is enabled by defining HALT_DET_EN.
module subleq_datapath #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          res,
   input  logic [2:0]    adr_reg_sel,
   input  logic          adr_dir,
   input  logic [2:0]    dat_reg_sel,
   input  logic          dat_dir,
   input  logic          ram_ope,
   input  logic          ram_ena,
   input  logic [1:0]    pc_mod,
   input  logic [DW-1:0] dat_in,
   output logic [DW-1:0] dat_out,
   output logic [AW-1:0] adr_out,
   output logic [DW-1:0] sub_out,
   output logic          sub_val
`ifdef HALT_DET_EN
   ,
   output logic          halt
`endif
);

   localparam logic [2:0] SEL_PC  = 3'd0;
   localparam logic [2:0] SEL_A   = 3'd1;
   localparam logic [2:0] SEL_B   = 3'd2;
   localparam logic [2:0] SEL_C   = 3'd3;
   localparam logic [2:0] SEL_VA  = 3'd4;
   localparam logic [2:0] SEL_VB  = 3'd5;
   localparam logic [2:0] SEL_RES = 3'd6;

   localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);

   logic [AW-1:0] pc;
   logic [DW-1:0] a, b, c, va, vb, rs;
   logic          pend;
   logic          load;

   logic [DW-1:0] rd_vec [8];
   logic [DW-1:0] pc_ext;
   logic [DW-1:0] adr_val;
   logic [AW-1:0] adr_val_aw;
   logic [AW-1:0] dat_in_aw;
   logic [AW-1:0] c_aw;

   // Width adaptation between the data and address domains.
   generate
      if (AW >= DW) begin : g_pc_trunc
         assign pc_ext = pc[DW-1:0];
      end else begin : g_pc_ext
         assign pc_ext = {{(DW-AW){1'b0}}, pc};
      end
      if (AW <= DW) begin : g_adr_trunc
         assign adr_val_aw = adr_val[AW-1:0];
         assign dat_in_aw  = dat_in[AW-1:0];
         assign c_aw       = c[AW-1:0];
      end else begin : g_adr_ext
         assign adr_val_aw = {{(AW-DW){1'b0}}, adr_val};
         assign dat_in_aw  = {{(AW-DW){1'b0}}, dat_in};
         assign c_aw       = {{(AW-DW){1'b0}}, c};
      end
   endgenerate

   always_comb begin
      rd_vec[0] = pc_ext;
      rd_vec[1] = a;
      rd_vec[2] = b;
      rd_vec[3] = c;
      rd_vec[4] = va;
      rd_vec[5] = vb;
      rd_vec[6] = rs;
      rd_vec[7] = '0;
   end

   assign adr_val = rd_vec[adr_reg_sel];
   assign adr_out = adr_dir ? adr_val_aw : '0;
   assign dat_out = dat_dir ? rd_vec[dat_reg_sel] : '0;
   assign sub_out = rs;

`ifdef HALT_DET_EN
   assign load = ram_ena && !ram_ope && !dat_dir && !halt;
`else
   assign load = ram_ena && !ram_ope && !dat_dir;
`endif

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pc      <= PC_INIT;
         a       <= '0;
         b       <= '0;
         c       <= '0;
         va      <= '0;
         vb      <= '0;
         rs      <= '0;
         pend    <= 1'b0;
         sub_val <= 1'b0;
`ifdef HALT_DET_EN
         halt    <= 1'b0;
`endif
      end else begin
         // A subtract already in flight still completes after halt.
         sub_val <= pend;
         if (pend) rs <= vb - va;
         pend <= 1'b0;

         if (load) begin
            case (dat_reg_sel)
               SEL_A:  a <= dat_in;
               SEL_B:  b <= dat_in;
               SEL_C:  c <= dat_in;
               SEL_VA: begin
                  va   <= dat_in;
                  pend <= 1'b1;
               end
               SEL_VB: begin
                  vb   <= dat_in;
                  pend <= 1'b1;
               end
               default: ;
            endcase
         end

`ifdef HALT_DET_EN
         if (!halt) begin
            case (pc_mod)
               2'b00: if (load && dat_reg_sel == SEL_PC) pc <= dat_in_aw;
               2'b01: pc <= pc + 1'b1;
               2'b10: begin
                  if (c[DW-1]) halt <= 1'b1;
                  else         pc   <= c_aw;
               end
               default: pc <= PC_INIT;
            endcase
         end
`else
         case (pc_mod)
            2'b00: if (load && dat_reg_sel == SEL_PC) pc <= dat_in_aw;
            2'b01: pc <= pc + 1'b1;
            2'b10: pc <= c_aw;
            default: pc <= PC_INIT;
         endcase
`endif
      end
   end

   // RES is intentionally absent from the load decode: only the subtractor writes it.
   logic unused_sel;
   assign unused_sel = (SEL_RES == 3'd6);

endmodule
